// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock supervisor: pulses the PLL reset, waits for lock with bounded
// retries, and holds sys_rst until lock has been stable for a programmable window.
module pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 50000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 3,
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count,
  output logic [7:0]         lock_loss_count
);

  // state       | meaning
  // ------------+-----------------------------------------------------------
  // RESET_PLL   | PLL held in reset for PLL_RST_CYCLES
  // WAIT_LOCK   | PLL released, waiting up to LOCK_TIMEOUT for lock
  // STABILIZE   | lock seen, must hold for LOCK_STABLE_CYCLES before release
  // RUN         | system reset released, watching for lock loss
  // FAULT       | retries exhausted; sticky until rst or relock_req

  localparam int CNT_MAX =
    (PLL_RST_CYCLES > LOCK_TIMEOUT)
      ? ((PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES)
      : ((LOCK_TIMEOUT > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT : LOCK_STABLE_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [RETRY_W-1:0]   retry_nxt;
  logic [7:0]           loss_nxt;
  logic                 lock_meta, locked_s;

  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      locked_s  <= lock_meta;
    end
  end

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_count;
    loss_nxt  = lock_loss_count;
    case (state)
      S_RESET_PLL: begin
        if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (locked_s) begin
          state_nxt = S_STABILIZE;
        end else if (cnt == TIMEOUT_LAST) begin
          if (retry_count == RETRY_LIMIT) begin
            state_nxt = S_FAULT;
          end else begin
            retry_nxt = retry_count + RETRY_W'(1);
            state_nxt = S_RESET_PLL;
          end
        end
      end
      S_STABILIZE: begin
        if (!locked_s)                state_nxt = S_WAIT_LOCK;
        else if (cnt == STABLE_LAST)  state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!locked_s) begin
          if (lock_loss_count != 8'hFF) loss_nxt = lock_loss_count + 8'd1;
          retry_nxt = '0;
          state_nxt = S_RESET_PLL;
        end else if (relock_req) begin
          state_nxt = S_RESET_PLL;
        end
      end
      S_FAULT: begin
        if (relock_req) begin
          retry_nxt = '0;
          state_nxt = S_RESET_PLL;
        end
      end
      default: state_nxt = S_RESET_PLL;
    endcase

    // The counter is idle in RUN and FAULT so it can never wrap there.
    if (state_nxt != state)                  cnt_nxt = '0;
    else if (state == S_RUN || state == S_FAULT) cnt_nxt = '0;
    else                                     cnt_nxt = cnt + CNT_W'(1);
  end

  // Outputs decode state_nxt so they change on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state           <= S_RESET_PLL;
      cnt             <= '0;
      pll_rst         <= 1'b1;
      sys_rst         <= 1'b1;
      ready           <= 1'b0;
      fault           <= 1'b0;
      retry_count     <= '0;
      lock_loss_count <= 8'd0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      pll_rst         <= (state_nxt == S_RESET_PLL) || (state_nxt == S_FAULT);
      sys_rst         <= (state_nxt != S_RUN);
      ready           <= (state_nxt == S_RUN);
      fault           <= (state_nxt == S_FAULT);
      retry_count     <= retry_nxt;
      lock_loss_count <= loss_nxt;
    end
  end

endmodule
